// File: rtl/tournament_predictor_n_if.sv
// Fetch/resolve port bundle for tournament_predictor_n.
// Ports: bp_ready, per-slot fetch_pc/fetch_branch and prediction outputs
//        (pred_taken, component predictions, pred_ghr checkpoint), plus a
//        single resolve channel carrying the checkpointed state back for training.
// master: fetch + branch-resolution side.  slave: the predictor.
interface tournament_predictor_n_if #(
  parameter int N         = 2,
  parameter int HIST_BITS = 5
);
  logic                          bp_ready;
  logic [N-1:0][31:0]            fetch_pc;
  logic [N-1:0]                  fetch_branch;
  logic [N-1:0]                  pred_taken;
  logic [N-1:0]                  pred_gshare_taken;
  logic [N-1:0]                  pred_simple_taken;
  logic [N-1:0][HIST_BITS-1:0]   pred_ghr;
  logic                          resolve_valid;
  logic [31:0]                   resolve_pc;
  logic [HIST_BITS-1:0]          resolve_ghr;
  logic                          resolve_gshare_taken;
  logic                          resolve_simple_taken;
  logic                          resolve_taken;
  logic                          resolve_mispred;

  modport master (
    input  bp_ready, pred_taken, pred_gshare_taken, pred_simple_taken, pred_ghr,
    output fetch_pc, fetch_branch,
    output resolve_valid, resolve_pc, resolve_ghr, resolve_gshare_taken,
           resolve_simple_taken, resolve_taken, resolve_mispred
  );

  modport slave (
    output bp_ready, pred_taken, pred_gshare_taken, pred_simple_taken, pred_ghr,
    input  fetch_pc, fetch_branch,
    input  resolve_valid, resolve_pc, resolve_ghr, resolve_gshare_taken,
           resolve_simple_taken, resolve_taken, resolve_mispred
  );
endinterface

// File: rtl/tournament_predictor_n.sv
// Purpose: N-wide tournament branch predictor (gshare + bimodal + chooser) with
//          speculative global history, checkpoint restore on mispredict, and a
//          post-reset sweep that initialises the tables (no reset on the arrays).
// Latency: predictions are combinational from fetch_pc/fetch_branch; training
//          and history updates take effect at the next clock edge.
// Backpressure: none; bp_ready stays low during the init sweep, during which
//          predictions read as zero and resolves are dropped.
// Ports: clk, rst (async, active-high); bp (tournament_predictor_n_if.slave):
//        fetch slots in, predictions/checkpoints out, one resolve per cycle in.
// Optional: define BP_STATS_EN to add stat_resolved / stat_mispred counters.
module tournament_predictor_n #(
  parameter int N            = 2,
  parameter int PHT_IDX_BITS = 5,
  parameter int HIST_BITS    = 5,
  parameter int CTR_BITS     = 2,
  parameter int CH_BITS      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  tournament_predictor_n_if.slave  bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0]              stat_resolved,
  output logic [31:0]              stat_mispred
`endif
);

  localparam int PHT_SZ = 1 << PHT_IDX_BITS;
  localparam logic [PHT_IDX_BITS-1:0] IDX_LAST = PHT_IDX_BITS'(PHT_SZ - 1);

  // Sweep values: gshare weakly taken, bimodal weakly not-taken,
  // chooser weakly favouring bimodal.
  localparam logic [CTR_BITS-1:0] GSH_INIT = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] BIM_INIT = GSH_INIT - CTR_BITS'(1);
  localparam logic [CH_BITS-1:0]  CH_INIT  = (CH_BITS'(1) << (CH_BITS - 1)) - CH_BITS'(1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                    state_q, state_d;
  logic [PHT_IDX_BITS-1:0]   init_idx_q;
  logic [HIST_BITS-1:0]      ghr_q, ghr_d;

  logic [CTR_BITS-1:0]       gshare_pht  [PHT_SZ];
  logic [CTR_BITS-1:0]       bimodal_pht [PHT_SZ];
  logic [CH_BITS-1:0]        chooser_pht [PHT_SZ];

  function automatic logic [CTR_BITS-1:0] ctr_train(input logic [CTR_BITS-1:0] ctr,
                                                    input logic up);
    ctr_train = ctr;
    if (up && (ctr != '1))
      ctr_train = ctr + CTR_BITS'(1);
    else if (!up && (ctr != '0))
      ctr_train = ctr - CTR_BITS'(1);
  endfunction

  function automatic logic [CH_BITS-1:0] ch_train(input logic [CH_BITS-1:0] ctr,
                                                  input logic up);
    ch_train = ctr;
    if (up && (ctr != '1))
      ch_train = ctr + CH_BITS'(1);
    else if (!up && (ctr != '0))
      ch_train = ctr - CH_BITS'(1);
  endfunction

  logic run;
  logic train;
  assign run   = (state_q == ST_RUN);
  assign train = run && bp.resolve_valid;
  assign bp.bp_ready = run;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q <= state_d;
      ghr_q   <= ghr_d;
      if (state_q == ST_INIT)
        init_idx_q <= init_idx_q + PHT_IDX_BITS'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (init_idx_q == IDX_LAST) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // ------------------------------------------------------- resolve path
  logic [PHT_IDX_BITS-1:0] r_sidx, r_gidx;
  logic [CTR_BITS-1:0]     g_new, b_new;
  logic [CH_BITS-1:0]      c_new;
  logic                    g_ok, s_ok;

  always_comb begin
    r_sidx = bp.resolve_pc[PHT_IDX_BITS+1:2];
    r_gidx = r_sidx ^ PHT_IDX_BITS'(bp.resolve_ghr);
    g_new  = ctr_train(gshare_pht[r_gidx], bp.resolve_taken);
    b_new  = ctr_train(bimodal_pht[r_sidx], bp.resolve_taken);
    g_ok   = (bp.resolve_gshare_taken == bp.resolve_taken);
    s_ok   = (bp.resolve_simple_taken == bp.resolve_taken);
    c_new  = chooser_pht[r_sidx];
    // Chooser only moves when exactly one component was right.
    if (g_ok && !s_ok)
      c_new = ch_train(chooser_pht[r_sidx], 1'b1);
    else if (s_ok && !g_ok)
      c_new = ch_train(chooser_pht[r_sidx], 1'b0);
  end

  // Tables carry no reset; the sweep rewrites every entry after each reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      gshare_pht[init_idx_q]  <= GSH_INIT;
      bimodal_pht[init_idx_q] <= BIM_INIT;
      chooser_pht[init_idx_q] <= CH_INIT;
    end else if (train) begin
      gshare_pht[r_gidx]  <= g_new;
      bimodal_pht[r_sidx] <= b_new;
      chooser_pht[r_sidx] <= c_new;
    end
  end

  // ---------------------------------------------------- prediction path
  logic [HIST_BITS-1:0]    hist;
  logic                    taken_seen;
  logic                    slot_pred;
  logic [PHT_IDX_BITS-1:0] p_sidx, p_gidx;
  logic [CTR_BITS-1:0]     g_ctr, b_ctr;
  logic [CH_BITS-1:0]      c_ctr;
  logic                    unused_pc_bits;

  always_comb begin
    hist                 = ghr_q;
    taken_seen           = 1'b0;
    slot_pred            = 1'b0;
    p_sidx               = '0;
    p_gidx               = '0;
    g_ctr                = '0;
    b_ctr                = '0;
    c_ctr                = '0;
    bp.pred_taken        = '0;
    bp.pred_gshare_taken = '0;
    bp.pred_simple_taken = '0;
    bp.pred_ghr          = '0;
    unused_pc_bits       = ^{bp.resolve_pc[31:PHT_IDX_BITS+2], bp.resolve_pc[1:0]};
    for (int i = 0; i < N; i++) begin
      unused_pc_bits = unused_pc_bits ^
                       (^{bp.fetch_pc[i][31:PHT_IDX_BITS+2], bp.fetch_pc[i][1:0]});
      // Each slot indexes gshare with the history as updated by older slots.
      p_sidx = bp.fetch_pc[i][PHT_IDX_BITS+1:2];
      p_gidx = p_sidx ^ PHT_IDX_BITS'(hist);
      // A resolve writing the same entry this cycle is forwarded so the
      // prediction already sees the trained counter.
      g_ctr  = (train && (p_gidx == r_gidx)) ? g_new : gshare_pht[p_gidx];
      b_ctr  = (train && (p_sidx == r_sidx)) ? b_new : bimodal_pht[p_sidx];
      c_ctr  = (train && (p_sidx == r_sidx)) ? c_new : chooser_pht[p_sidx];
      if (run) begin
        bp.pred_ghr[i]          = hist;
        bp.pred_gshare_taken[i] = g_ctr[CTR_BITS-1];
        bp.pred_simple_taken[i] = b_ctr[CTR_BITS-1];
        // Slots after the first predicted-taken branch are off-path.
        if (bp.fetch_branch[i] && !taken_seen) begin
          slot_pred        = c_ctr[CH_BITS-1] ? g_ctr[CTR_BITS-1] : b_ctr[CTR_BITS-1];
          bp.pred_taken[i] = slot_pred;
          hist             = (hist << 1) | HIST_BITS'(slot_pred);
          taken_seen       = slot_pred;
        end
      end
    end
  end

  // Mispredict restores the checkpoint plus the real outcome and discards
  // whatever the current fetch group would have shifted in.
  always_comb begin
    ghr_d = ghr_q;
    if (run) begin
      if (bp.resolve_valid && bp.resolve_mispred)
        ghr_d = (bp.resolve_ghr << 1) | HIST_BITS'(bp.resolve_taken);
      else
        ghr_d = hist;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else if (train) begin
      if (stat_resolved != '1)
        stat_resolved <= stat_resolved + 32'd1;
      if (bp.resolve_mispred && (stat_mispred != '1))
        stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule
